wiz_bus_seq: RTL and testbench

Bus-cycle sequencer and arbiter for the W5300 8-bit host interface in the ZXiznet CPLD. Takes mapped 10-bit W5300 addresses from the Z80 side and an internal interrupt-register poller, grants one access at a time, and drives the W5300 CS/RD/WR strobes with parameterised setup/strobe/hold timing. It replaces direct combinational strobe generation and gives the Z80 a req/ack handshake and a latched interrupt line.

---
 rtl/wiz_bus_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_wiz_bus_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wiz_bus_seq.sv
// W5300 host-bus cycle sequencer: arbitrates Z80 host accesses against an interrupt-register poller.
// Define WIZSEQ_POLL_EN to build the poller, ir_status and irq logic; otherwise only host cycles run.
module wiz_bus_seq #(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 4,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned POLL_PERIOD = 1024,
    parameter logic [9:0]  IR_ADDR     = 10'h002
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic       host_req,
    input  logic       host_rnw,
    input  logic [9:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_ack,
    output logic [7:0] host_rdata,
    input  logic       poll_en,
    input  logic [7:0] irq_mask,
    output logic       irq,
    output logic       busy,
    output logic [9:0] w5300_addr,
    output logic [7:0] w5300_dout,
    output logic       w5300_doe,
    input  logic [7:0] w5300_din,
    output logic       w5300_cs_n,
    output logic       w5300_rd_n,
    output logic       w5300_wr_n
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       owner_poll_q, owner_poll_d;
    logic       rnw_q, rnw_d;
    logic [9:0] addr_q, addr_d;
    logic [7:0] dout_q, dout_d;
    logic       doe_q, doe_d;
    logic       cs_n_q, cs_n_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic       host_ack_q, host_ack_d;
    logic [7:0] host_rdata_q, host_rdata_d;
    logic [7:0] rd_buf_q, rd_buf_d;

    logic       poll_pend, poll_force;
    logic       grant_poll, poll_done, host_ir_clr;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_poll_d = owner_poll_q;
        rnw_d        = rnw_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        doe_d        = doe_q;
        cs_n_d       = cs_n_q;
        rd_n_d       = 1'b1;
        wr_n_d       = 1'b1;
        host_ack_d   = 1'b0;
        host_rdata_d = host_rdata_q;
        rd_buf_d     = rd_buf_q;
        grant_poll   = 1'b0;
        poll_done    = 1'b0;
        host_ir_clr  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The ack cycle never grants, so a host still holding req there is not re-served.
                if (!host_ack_q && (poll_force || host_req || poll_pend)) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LD;
                    cs_n_d  = 1'b0;
                    if (poll_force || !host_req) begin
                        grant_poll   = 1'b1;
                        owner_poll_d = 1'b1;
                        rnw_d        = 1'b1;
                        addr_d       = IR_ADDR;
                        doe_d        = 1'b0;
                    end else begin
                        owner_poll_d = 1'b0;
                        rnw_d        = host_rnw;
                        addr_d       = host_addr;
                        dout_d       = host_wdata;
                        doe_d        = !host_rnw;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LD;
                    rd_n_d  = !rnw_q;
                    wr_n_d  = rnw_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d  = ST_HOLD;
                    cnt_d    = HOLD_LD;
                    rd_buf_d = w5300_din;
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    rd_n_d = !rnw_q;
                    wr_n_d = rnw_q;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                    cs_n_d  = 1'b1;
                    doe_d   = 1'b0;
                    if (owner_poll_q) begin
                        poll_done = 1'b1;
                    end else begin
                        host_ack_d  = 1'b1;
                        host_ir_clr = (addr_q == IR_ADDR);
                        if (rnw_q) host_rdata_d = rd_buf_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            owner_poll_q <= 1'b0;
            rnw_q        <= 1'b1;
            addr_q       <= 10'd0;
            dout_q       <= 8'd0;
            doe_q        <= 1'b0;
            cs_n_q       <= 1'b1;
            rd_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            host_ack_q   <= 1'b0;
            host_rdata_q <= 8'd0;
            rd_buf_q     <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_poll_q <= owner_poll_d;
            rnw_q        <= rnw_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            doe_q        <= doe_d;
            cs_n_q       <= cs_n_d;
            rd_n_q       <= rd_n_d;
            wr_n_q       <= wr_n_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
            rd_buf_q     <= rd_buf_d;
        end
    end

`ifdef WIZSEQ_POLL_EN
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        poll_pend_q, poll_pend_d;
    logic        poll_force_q, poll_force_d;
    logic [7:0]  ir_status_q, ir_status_d;
    logic        irq_q, irq_d;
    logic        poll_wrap;

    always_comb begin
        poll_cnt_d   = 16'd0;
        poll_pend_d  = 1'b0;
        poll_force_d = 1'b0;
        ir_status_d  = 8'd0;
        poll_wrap    = (poll_cnt_q == 16'(POLL_PERIOD - 1));
        irq_d        = |(ir_status_q & irq_mask);
        if (poll_en) begin
            poll_cnt_d   = poll_wrap ? 16'd0 : poll_cnt_q + 16'd1;
            poll_pend_d  = poll_pend_q && !grant_poll;
            poll_force_d = poll_force_q && !grant_poll;
            // A wrap landing on the grant edge re-arms the request for the next period.
            if (poll_wrap) begin
                poll_pend_d = 1'b1;
                if (poll_pend_q) poll_force_d = 1'b1;
            end
            ir_status_d = ir_status_q;
            if (poll_done)   ir_status_d = rd_buf_q;
            if (host_ir_clr) ir_status_d = 8'd0;
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt_q   <= 16'd0;
            poll_pend_q  <= 1'b0;
            poll_force_q <= 1'b0;
            ir_status_q  <= 8'd0;
            irq_q        <= 1'b0;
        end else begin
            poll_cnt_q   <= poll_cnt_d;
            poll_pend_q  <= poll_pend_d;
            poll_force_q <= poll_force_d;
            ir_status_q  <= ir_status_d;
            irq_q        <= irq_d;
        end
    end

    assign poll_pend  = poll_pend_q;
    assign poll_force = poll_force_q;
    assign irq        = irq_q;
`else
    logic unused_poll;
    assign unused_poll = ^{poll_en, irq_mask, grant_poll, poll_done, host_ir_clr};
    assign poll_pend   = 1'b0;
    assign poll_force  = 1'b0;
    assign irq         = 1'b0;
`endif

    assign busy       = (state_q != ST_IDLE);
    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;
    assign w5300_addr = addr_q;
    assign w5300_dout = dout_q;
    assign w5300_doe  = doe_q;
    assign w5300_cs_n = cs_n_q;
    assign w5300_rd_n = rd_n_q;
    assign w5300_wr_n = wr_n_q;

endmodule

// File: tb/tb_wiz_bus_seq.sv
// Self-checking bench for wiz_bus_seq: default-timing instance (POLL_PERIOD=16) and a 1/1/1 instance.
module tb_wiz_bus_seq;
    localparam int S = 1, T = 4, H = 1, P = 16;
    localparam logic [9:0] IRA = 10'h002;

    logic       fclk = 1'b0;
    logic       rst_n;
    logic       m_req, f_req, rnw, poll_en;
    logic [9:0] addr;
    logic [7:0] wdata, din, mask;

    logic       m_ack, m_irq, m_busy, m_doe, m_cs_n, m_rd_n, m_wr_n;
    logic [7:0] m_rdata, m_dout;
    logic [9:0] m_addr;
    logic       f_ack, f_irq, f_busy, f_doe, f_cs_n, f_rd_n, f_wr_n;
    logic [7:0] f_rdata, f_dout;
    logic [9:0] f_addr;

    int n_cmp = 0, n_err = 0;
    logic sel = 1'b0;
    logic [7:0] exp_rdata [2];
    logic irq_at_ack;
    int mdl_edge[$], obs_edge[$];
    bit mdl_poll[$], obs_poll[$];

    always #5 fclk = ~fclk;

    wiz_bus_seq #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .POLL_PERIOD(P), .IR_ADDR(IRA)) u_main (
        .fclk(fclk), .rst_n(rst_n), .host_req(m_req), .host_rnw(rnw), .host_addr(addr),
        .host_wdata(wdata), .host_ack(m_ack), .host_rdata(m_rdata), .poll_en(poll_en),
        .irq_mask(mask), .irq(m_irq), .busy(m_busy), .w5300_addr(m_addr), .w5300_dout(m_dout),
        .w5300_doe(m_doe), .w5300_din(din), .w5300_cs_n(m_cs_n), .w5300_rd_n(m_rd_n),
        .w5300_wr_n(m_wr_n));

    wiz_bus_seq #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .POLL_PERIOD(P), .IR_ADDR(IRA)) u_fast (
        .fclk(fclk), .rst_n(rst_n), .host_req(f_req), .host_rnw(rnw), .host_addr(addr),
        .host_wdata(wdata), .host_ack(f_ack), .host_rdata(f_rdata), .poll_en(1'b0),
        .irq_mask(8'h00), .irq(f_irq), .busy(f_busy), .w5300_addr(f_addr), .w5300_dout(f_dout),
        .w5300_doe(f_doe), .w5300_din(din), .w5300_cs_n(f_cs_n), .w5300_rd_n(f_rd_n),
        .w5300_wr_n(f_wr_n));

    logic       s_ack, s_doe, s_cs_n, s_rd_n, s_wr_n;
    logic [7:0] s_rdata, s_dout;
    logic [9:0] s_addr;
    assign s_ack   = sel ? f_ack   : m_ack;
    assign s_doe   = sel ? f_doe   : m_doe;
    assign s_cs_n  = sel ? f_cs_n  : m_cs_n;
    assign s_rd_n  = sel ? f_rd_n  : m_rd_n;
    assign s_wr_n  = sel ? f_wr_n  : m_wr_n;
    assign s_rdata = sel ? f_rdata : m_rdata;
    assign s_dout  = sel ? f_dout  : m_dout;
    assign s_addr  = sel ? f_addr  : m_addr;

    // One host access; din only carries the read value while the strobe is low.
    task automatic host_xact(input bit s, input bit r, input logic [9:0] a, input logic [7:0] wd,
                             input logic [7:0] dv, input int ns, input int nt, input int nh);
        int cs_lo = 0, stb_lo = 0, first_stb = 0, ack_cyc = 0, bad_bus = 0;
        sel = s;
        @(negedge fclk);
        rnw = r; addr = a; wdata = wd; din = ~dv;
        if (s) f_req = 1'b1; else m_req = 1'b1;
        for (int c = 1; c <= 40 && ack_cyc == 0; c++) begin
            @(negedge fclk);
            if (!s_cs_n) cs_lo++;
            if (!(r ? s_rd_n : s_wr_n)) begin
                stb_lo++;
                if (first_stb == 0) first_stb = c;
            end
            if (!(r ? s_wr_n : s_rd_n)) bad_bus++;
            if (!s_cs_n && (s_addr !== a || s_doe !== !r || (!r && s_dout !== wd))) bad_bus++;
            din = (!s_rd_n) ? dv : ~dv;
            if (s_ack === 1'b1) begin
                ack_cyc = c; m_req = 1'b0; f_req = 1'b0; irq_at_ack = m_irq;
            end
        end
        m_req = 1'b0; f_req = 1'b0;
        if (r) exp_rdata[s] = dv;
        n_cmp++; if (ack_cyc !== 1 + ns + nt + nh) begin n_err++; $display("FAIL ack_cycle: got %0d want %0d", ack_cyc, 1 + ns + nt + nh); end
        n_cmp++; if (cs_lo !== ns + nt + nh) begin n_err++; $display("FAIL cs_low_cycles: got %0d want %0d", cs_lo, ns + nt + nh); end
        n_cmp++; if (stb_lo !== nt || first_stb !== 1 + ns) begin n_err++; $display("FAIL strobe_window: got %0d cyc from %0d want %0d from %0d", stb_lo, first_stb, nt, 1 + ns); end
        n_cmp++; if (bad_bus !== 0) begin n_err++; $display("FAIL bus_fields: got %0d bad cycles want 0 (addr %h)", bad_bus, a); end
        n_cmp++; if (s_rdata !== exp_rdata[s]) begin n_err++; $display("FAIL host_rdata: got %h want %h", s_rdata, exp_rdata[s]); end
        @(negedge fclk);
        n_cmp++; if (s_ack !== 1'b0) begin n_err++; $display("FAIL ack_pulse_width: got %b want 0", s_ack); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; m_req = 1'b0; f_req = 1'b0; rnw = 1'b1; addr = '0; wdata = '0;
        din = '0; mask = '0; poll_en = 1'b0;
        exp_rdata[0] = 8'h00; exp_rdata[1] = 8'h00;
        repeat (3) @(negedge fclk);
        n_cmp++; if ({m_cs_n, m_rd_n, m_wr_n, m_doe, m_ack, m_irq, m_busy} !== 7'b1110000) begin
            n_err++; $display("FAIL reset_ctrl_main: got %b want 1110000", {m_cs_n, m_rd_n, m_wr_n, m_doe, m_ack, m_irq, m_busy}); end
        rst_n = 1'b1;
        @(negedge fclk);
        n_cmp++; if ({m_addr, m_dout, m_rdata} !== 26'd0) begin
            n_err++; $display("FAIL reset_data_main: got %h %h %h want 0", m_addr, m_dout, m_rdata); end
        n_cmp++; if ({f_cs_n, f_rd_n, f_wr_n, f_doe, f_ack, f_busy, f_addr, f_rdata} !== {6'b111000, 18'd0}) begin
            n_err++; $display("FAIL reset_fast: got %b %h %h", {f_cs_n, f_rd_n, f_wr_n, f_doe, f_ack, f_busy}, f_addr, f_rdata); end
    endtask

    task automatic test_write_default();
        host_xact(1'b0, 1'b0, 10'h123, 8'hA5, 8'h00, S, T, H);
    endtask

    task automatic test_read_hold();
        host_xact(1'b0, 1'b1, 10'h2AB, 8'h00, 8'h3C, S, T, H);
        host_xact(1'b0, 1'b0, 10'h0F0, 8'h5A, 8'h77, S, T, H);
        n_cmp++; if (m_rdata !== 8'h3C) begin n_err++; $display("FAIL rdata_hold: got %h want 3c", m_rdata); end
    endtask

    task automatic test_fast_latency();
        host_xact(1'b1, 1'b0, 10'h3FE, 8'h81, 8'h00, 1, 1, 1);
        host_xact(1'b1, 1'b1, 10'h001, 8'h00, 8'hE7, 1, 1, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++)
            host_xact(1'(i % 3 == 2), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      (i % 3 == 2) ? 1 : S, (i % 3 == 2) ? 1 : T, (i % 3 == 2) ? 1 : H);
    endtask

    // Transaction-level arbitration model for a host that never drops its request.
    function automatic void model_stream(input bit pen);
        int free = 0;
        bit pend = 0, frc = 0, pold, wrap, gp;
        mdl_edge.delete(); mdl_poll.delete();
        for (int k = 0; k < 60; k++) begin
            wrap = pen && (k % P == P - 1);
            pold = pend;
            gp = 0;
            if (k >= free) begin
                mdl_edge.push_back(k);
                if (frc) begin
                    gp = 1; mdl_poll.push_back(1'b1); free = k + S + T + H + 1;
                end else begin
                    mdl_poll.push_back(1'b0); free = k + S + T + H + 2;
                end
            end
            if (gp) begin pend = 0; frc = 0; end
            if (wrap) begin if (pold) frc = 1; pend = 1; end
        end
    endfunction

    task automatic test_stream(input bit pen, input string tag);
        logic prev_cs = 1'b1;
        int waited = 0;
`ifdef WIZSEQ_POLL_EN
        model_stream(pen);
`else
        model_stream(1'b0);
`endif
        obs_edge.delete(); obs_poll.delete();
        sel = 1'b0;
        @(negedge fclk);
        poll_en = pen; m_req = 1'b1; rnw = 1'b1; addr = 10'h155; din = 8'h00;
        for (int c = 1; c <= 60; c++) begin
            @(negedge fclk);
            if (prev_cs && !m_cs_n) begin
                obs_edge.push_back(c - 1);
                obs_poll.push_back(m_addr == IRA);
            end
            prev_cs = m_cs_n;
        end
        m_req = 1'b0; poll_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (i >= obs_edge.size()) begin
                n_err++; $display("FAIL %s_grant%0d: got none want edge %0d poll=%0d", tag, i, mdl_edge[i], mdl_poll[i]);
            end else if (obs_edge[i] !== mdl_edge[i] || obs_poll[i] !== mdl_poll[i]) begin
                n_err++; $display("FAIL %s_grant%0d: got edge %0d poll=%0d want edge %0d poll=%0d",
                                  tag, i, obs_edge[i], obs_poll[i], mdl_edge[i], mdl_poll[i]);
            end
        end
        while (m_busy && waited < 40) begin @(negedge fclk); waited++; end
        n_cmp++; if (m_busy !== 1'b0) begin n_err++; $display("FAIL %s_drain: got busy %b want 0", tag, m_busy); end
        repeat (2) @(negedge fclk);
        exp_rdata[0] = 8'h00;
    endtask

    task automatic test_poll_irq();
`ifdef WIZSEQ_POLL_EN
        int irq_cyc = 0, waited = 0;
        bit poll_seen = 0;
        logic prev_cs = 1'b1;
        @(negedge fclk);
        mask = 8'h04; din = 8'h04; poll_en = 1'b1;
        for (int c = 1; c <= 60 && irq_cyc == 0; c++) begin
            @(negedge fclk);
            if (prev_cs && !m_cs_n && m_addr == IRA && m_doe == 1'b0) poll_seen = 1;
            prev_cs = m_cs_n;
            if (m_irq === 1'b1) irq_cyc = c;
        end
        n_cmp++; if (!poll_seen) begin n_err++; $display("FAIL poll_access: got none want read of %h", IRA); end
        n_cmp++; if (irq_cyc !== P + S + T + H + 2) begin n_err++; $display("FAIL irq_rise_cycle: got %0d want %0d", irq_cyc, P + S + T + H + 2); end
        mask = 8'hFB;
        @(negedge fclk);
        n_cmp++; if (m_irq !== 1'b0) begin n_err++; $display("FAIL irq_masked: got %b want 0", m_irq); end
        mask = 8'h04;
        @(negedge fclk);
        n_cmp++; if (m_irq !== 1'b1) begin n_err++; $display("FAIL irq_unmasked: got %b want 1", m_irq); end
        host_xact(1'b0, 1'b1, IRA, 8'h00, 8'h04, S, T, H);
        n_cmp++; if (irq_at_ack !== 1'b1 || m_irq !== 1'b0) begin
            n_err++; $display("FAIL irq_clear: got %b then %b want 1 then 0", irq_at_ack, m_irq); end
        din = 8'h00; poll_en = 1'b0;
        while (m_busy && waited < 40) begin @(negedge fclk); waited++; end
        repeat (2) @(negedge fclk);
        n_cmp++; if (m_irq !== 1'b0 || m_busy !== 1'b0) begin n_err++; $display("FAIL poll_disable: got irq %b busy %b want 0 0", m_irq, m_busy); end
`else
        int irq_hi = 0, cs_lo = 0;
        @(negedge fclk);
        mask = 8'hFF; din = 8'hFF; poll_en = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge fclk);
            if (m_irq !== 1'b0) irq_hi++;
            if (m_cs_n !== 1'b1) cs_lo++;
        end
        poll_en = 1'b0; mask = 8'h00;
        n_cmp++; if (irq_hi !== 0) begin n_err++; $display("FAIL irq_tied_off: got %0d high cycles want 0", irq_hi); end
        n_cmp++; if (cs_lo !== 0) begin n_err++; $display("FAIL no_poll_cycles: got %0d cs low cycles want 0", cs_lo); end
`endif
    endtask

    task automatic test_reset_midstrobe();
        int waited = 0, acks = 0, busy_cyc = 0;
        sel = 1'b0;
        @(negedge fclk);
        rnw = 1'b0; addr = 10'h3FF; wdata = 8'hC3; m_req = 1'b1;
        while (m_wr_n !== 1'b0 && waited < 20) begin @(negedge fclk); waited++; end
        n_cmp++; if (m_wr_n !== 1'b0) begin n_err++; $display("FAIL reach_strobe: got wr_n %b want 0", m_wr_n); end
        @(negedge fclk);
        m_req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if ({m_cs_n, m_wr_n, m_rd_n, m_doe, m_busy} !== 5'b11100) begin
            n_err++; $display("FAIL async_reset_strobes: got %b want 11100", {m_cs_n, m_wr_n, m_rd_n, m_doe, m_busy}); end
        @(negedge fclk);
        rst_n = 1'b1;
        exp_rdata[0] = 8'h00; exp_rdata[1] = 8'h00;
        for (int c = 0; c < 12; c++) begin
            @(negedge fclk);
            if (m_ack !== 1'b0) acks++;
            if (m_busy !== 1'b0) busy_cyc++;
        end
        n_cmp++; if (acks !== 0 || busy_cyc !== 0) begin n_err++; $display("FAIL post_reset_idle: got %0d acks %0d busy want 0 0", acks, busy_cyc); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_default();
        test_read_hold();
        test_fast_latency();
        test_random();
        test_stream(1'b0, "back_to_back");
        test_stream(1'b1, "poll_force");
        test_poll_irq();
        test_reset_midstrobe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
